loop_sequencer: RTL
===================

Name: loop_sequencer

Overview:
- Multi-track, tempo-timed key sequencer; next-generation recorder/player between keyboard_tracker key outputs and the tone/LED output stage.
- Records the held key on every step tick into one of NUM_TRACKS tracks of DEPTH steps, preserving rests and timing.
- Plays a track back one step per tick, once or looped. In IDLE, passes the live key through.

Parameters:
NUM_KEYS, 9, number of key inputs (q..o)
DEPTH, 16, steps per track
NUM_TRACKS, 2, independent tracks
TICK_DIV, 12500000, clock cycles per step (4 Hz at 50 MHz); minimum 2

Ports:
clock  in  1  system clock (CLOCK_50 domain)
reset  in  1  synchronous, active-high
pressed  in  NUM_KEYS  held-key levels from keyboard_tracker
track_sel  in  TW=max(1,clog2(NUM_TRACKS))  track for record/play/clear
rec  in  1  level; record request
play  in  1  level; playback request
loop  in  1  level; playback wraps instead of stopping
clear  in  1  single-cycle; empties selected track
note  out  KW=clog2(NUM_KEYS+1)  current note index; 0 = silence
state_o  out  2  0 IDLE, 1 RECORD, 2 PLAY, 3 WAIT
full  out  1  active track length == DEPTH
step  out  DW=clog2(DEPTH+1)  current record/play step index
track_len  out  DW  length of track_sel track

Behaviour:
- Key encoding enc(pressed): exactly one bit k set -> k+1. Zero bits or more than one bit set -> 0 (rest).
- Reset:
  - state IDLE; note=0; step=0; all track lengths=0; tick counter=0.
  - Memory contents are don't-care.
- Tick:
  - Counter runs 0..TICK_DIV-1. tick is high in the cycle where count==TICK_DIV-1, then count wraps to 0.
  - Counter is forced to 0 on the cycle of entry into RECORD or PLAY. The first tick therefore arrives TICK_DIV cycles after entry.
- Active track: track_sel is latched on entry into RECORD/PLAY and ignored until the block returns to IDLE.
- IDLE:
  - note <= enc(pressed) (1-cycle registered latency).
  - rec=1 -> RECORD: len[sel]<=0, step<=0. rec has priority over play.
  - Otherwise play=1 and len[sel]>0 -> PLAY: step<=0, note<=mem[sel][0].
  - play=1 with len[sel]==0 -> stay IDLE.
  - clear=1 (and rec=0, play=0) -> len[sel]<=0.
- RECORD:
  - note <= enc(pressed) (monitor).
  - On tick: mem[act][step]<=enc(pressed), step++, len++.
  - When len reaches DEPTH, full=1 and the state goes to WAIT.
  - rec=0 -> IDLE next cycle. The partial length is kept; a tick in the same cycle is still written.
- PLAY:
  - note = mem[act][step], updated the cycle after step changes.
  - On tick:
    - If step==len-1 and loop=1: step<=0.
    - If step==len-1 and loop=0: WAIT, note<=0.
    - Otherwise step++.
  - play=0 -> IDLE next cycle, note resumes live.
  - rec is ignored while in PLAY.
- WAIT: note=0. Go to IDLE only when rec=0 and play=0, which prevents immediate re-record or replay.
- clear is ignored outside IDLE. clear has no effect on memory contents, only on length.
- Reset mid-RECORD/PLAY: immediate return to reset state; all lengths zeroed.
- Tracks are independent: recording track 1 never alters len or mem of track 0.
- Memory: NUM_TRACKS*DEPTH words of KW bits; synchronous write, asynchronous or registered read, with the note timing above preserved.

Test Plan:
- Live pass-through: TICK_DIV=4. pressed=9'b000100000 (bit 5) -> note=6 one cycle later. pressed=9'b000100001 -> note=0.
- Record with rests, track 0: rec=1; hold bit 8 for ticks 1-2, nothing for tick 3, bit 0 for tick 4, then rec=0 -> len=4, contents {9,9,0,1}, state IDLE.
- Playback once: play=1, loop=0, track 0 -> note sequence 9,9,0,1, each held 4 cycles (first held from entry to first tick). Then WAIT with note=0; IDLE after play=0.
- Loop and full: DEPTH=4, record 4 steps on track 1 -> full=1, WAIT until rec=0. Play with loop=1 for 10 ticks -> step sequence 0,1,2,3,0,1,2,3,0,1. Track 0 len still 4.
- Clear and empty play: clear with track_sel=1 -> track_len=0. play=1 with track_sel=1 -> stays IDLE, note follows live keys.
- Reset mid-PLAY at step 2 -> next cycle state=IDLE, note=0, all lengths 0.

Source files
------------

// File: rtl/loop_sequencer.sv
// loop_sequencer: multi-track, tick-timed key recorder/player.
// Sits between the keyboard_tracker key levels and the tone/LED stage.
// In IDLE the live key is passed through. In RECORD, the encoded key is
// stored once per step tick into the selected track. In PLAY, the stored
// track is replayed one step per tick, either once or looped.
//
// Ports:
//   clock      system clock (CLOCK_50 domain)
//   reset      synchronous, active-high
//   pressed    held-key levels, one bit per key
//   track_sel  track used for record/play/clear (latched on entry)
//   rec        level, record request (wins over play in IDLE)
//   play       level, playback request
//   loop       level, playback wraps instead of stopping
//   clear      single-cycle, empties the selected track (IDLE only)
//   note       current note index, 0 = silence
//   state_o    0 IDLE, 1 RECORD, 2 PLAY, 3 WAIT
//   full       active track length equals DEPTH
//   step       current record/play step index
//   track_len  length of the track addressed by track_sel
module loop_sequencer #(
    parameter int unsigned NUM_KEYS   = 9,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned NUM_TRACKS = 2,
    parameter int unsigned TICK_DIV   = 12500000,
    localparam int unsigned TW = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1,
    localparam int unsigned KW = $clog2(NUM_KEYS + 1),
    localparam int unsigned DW = $clog2(DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] pressed,
    input  logic [TW-1:0]       track_sel,
    input  logic                rec,
    input  logic                play,
    input  logic                loop,
    input  logic                clear,
    output logic [KW-1:0]       note,
    output logic [1:0]          state_o,
    output logic                full,
    output logic [DW-1:0]       step,
    output logic [DW-1:0]       track_len
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECORD = 2'd1,
        S_PLAY   = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    state_t          state, state_next;
    logic [TW-1:0]   act, act_next;
    logic [DW-1:0]   step_next;
    logic [KW-1:0]   note_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic            cnt_clr;
    logic            tick;
    logic            wr_en;
    logic [KW-1:0]   live_key;
    logic [DW-1:0]   len      [NUM_TRACKS];
    logic [DW-1:0]   len_next [NUM_TRACKS];
    logic [KW-1:0]   mem      [NUM_TRACKS][DEPTH];

    // One-hot key to index+1; no key or a chord is treated as a rest.
    function automatic logic [KW-1:0] key_enc(input logic [NUM_KEYS-1:0] keys);
        logic [KW-1:0] idx;
        int unsigned   ones;
        idx  = '0;
        ones = 0;
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            if (keys[k]) begin
                ones++;
                idx = KW'(k + 1);
            end
        end
        return (ones == 1) ? idx : '0;
    endfunction

    assign live_key = key_enc(pressed);
    assign tick     = (cnt == CW'(TICK_DIV - 1));
    assign state_o  = state;

    // Next-state, step, length and note decisions.
    always_comb begin
        state_next = state;
        act_next   = act;
        step_next  = step;
        note_next  = note;
        len_next   = len;
        cnt_clr    = 1'b0;
        wr_en      = 1'b0;

        case (state)
            S_IDLE: begin
                note_next = live_key;
                if (rec) begin
                    state_next          = S_RECORD;
                    act_next            = track_sel;
                    len_next[track_sel] = '0;
                    step_next           = '0;
                    cnt_clr             = 1'b1;
                end else if (play && (len[track_sel] != '0)) begin
                    state_next = S_PLAY;
                    act_next   = track_sel;
                    step_next  = '0;
                    note_next  = mem[track_sel][AW'(0)];
                    cnt_clr    = 1'b1;
                end else if (clear && !play) begin
                    len_next[track_sel] = '0;
                end
            end

            S_RECORD: begin
                note_next = live_key;
                // A tick coinciding with rec dropping is still captured.
                if (tick) begin
                    wr_en         = 1'b1;
                    len_next[act] = len[act] + DW'(1);
                    step_next     = step + DW'(1);
                end
                if (!rec) begin
                    state_next = S_IDLE;
                end else if (tick && ((len[act] + DW'(1)) == DW'(DEPTH))) begin
                    state_next = S_WAIT;
                    note_next  = '0;
                end
            end

            S_PLAY: begin
                if (!play) begin
                    state_next = S_IDLE;
                    note_next  = live_key;
                end else if (tick) begin
                    if ((step + DW'(1)) == len[act]) begin
                        if (loop) begin
                            step_next = '0;
                            note_next = mem[act][AW'(0)];
                        end else begin
                            state_next = S_WAIT;
                            note_next  = '0;
                        end
                    end else begin
                        step_next = step + DW'(1);
                        note_next = mem[act][step_next[AW-1:0]];
                    end
                end
            end

            S_WAIT: begin
                // Hold silence until both requests are released.
                note_next = '0;
                if (!rec && !play) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        cnt_next = (tick || cnt_clr) ? '0 : cnt + CW'(1);
    end

    // Control and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            act       <= '0;
            step      <= '0;
            note      <= '0;
            cnt       <= '0;
            full      <= 1'b0;
            track_len <= '0;
            len       <= '{default: '0};
        end else begin
            state     <= state_next;
            act       <= act_next;
            step      <= step_next;
            note      <= note_next;
            cnt       <= cnt_next;
            len       <= len_next;
            full      <= (len_next[act_next] == DW'(DEPTH));
            track_len <= len_next[track_sel];
        end
    end

    // Step memory; contents are not reset, only lengths are.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[act][step[AW-1:0]] <= live_key;
        end
    end

endmodule
